// File: rtl/pmem_responder.sv
// pmem_responder: single-outstanding physical-memory model for the cache pmem port.
// Accepts one 128-bit line read or write, holds it for LATENCY cycles, then
// commits the write or loads the read line and pulses pmem_resp for one cycle.
// Optional statistics counters are compiled in when PMEM_STATS_EN is defined.
module pmem_responder #(
  parameter int LATENCY  = 4,
  parameter int IDX_BITS = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         pmem_busy
`ifdef PMEM_STATS_EN
  ,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
`endif
);

  localparam int DEPTH = 1 << IDX_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  is_write_q, is_write_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [127:0]          wdata_q, wdata_d;
  logic [127:0]          rdata_q, rdata_d;

  // Line array: deliberately not reset so contents survive rst.
  logic [127:0]          mem [DEPTH];

  logic                  mem_we;
  logic                  mem_re;
  logic [IDX_BITS-1:0]   mem_idx;
  logic [127:0]          mem_wdata;
  logic [IDX_BITS-1:0]   live_idx;
  logic                  unused_addr_bits;

  // Low nibble (and any bits above the index) do not select a line.
  assign live_idx         = pmem_address[IDX_BITS+3:4];
  assign unused_addr_bits = ^pmem_address;

  // State and request registers; reset discards any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // Array write port; a commit on the same edge as rst is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  // Next-state logic: accept, count down, abort, and schedule the commit/load.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_idx    = idx_q;
    mem_wdata  = wdata_q;
    case (state_q)
      IDLE: begin
        if (pmem_write || pmem_read) begin
          // Write wins when both request lines are high.
          is_write_d = pmem_write;
          idx_d      = live_idx;
          wdata_d    = pmem_wdata;
          cnt_d      = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            // No wait phase: commit or load straight from the live inputs.
            state_d   = RESP;
            mem_idx   = live_idx;
            mem_wdata = pmem_wdata;
            mem_we    = pmem_write;
            mem_re    = !pmem_write;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (is_write_q ? !pmem_write : !pmem_read) begin
          // Requester withdrew: abandon silently, nothing committed.
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RESP;
            mem_we  = is_write_q;
            mem_re  = !is_write_q;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read data register only changes when a read completes.
  always_comb begin
    rdata_d = rdata_q;
    if (mem_re) begin
      rdata_d = mem[mem_idx];
    end
  end

  // Outputs are pure decodes of registered state.
  always_comb begin
    pmem_resp  = (state_q == RESP);
    pmem_busy  = (state_q != IDLE);
    pmem_rdata = rdata_q;
  end

`ifdef PMEM_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  // Saturating completion counters, bumped once per response pulse.
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (state_q == RESP) begin
      if (is_write_q) begin
        if (wr_count_q != 16'hFFFF) begin
          wr_count_d = wr_count_q + 16'd1;
        end
      end else begin
        if (rd_count_q != 16'hFFFF) begin
          rd_count_d = rd_count_q + 16'd1;
        end
      end
    end
  end

  // Counter registers, cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Testbench for pmem_responder: one instance at LATENCY=4, one at LATENCY=1.
// A scoreboard queue per instance holds the expected completions in order;
// a negedge monitor pops and compares whenever pmem_resp is seen.
module tb_pmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst   [2];
  logic         rd    [2];
  logic         wr    [2];
  logic         resp  [2];
  logic         busy  [2];
  logic [15:0]  addr  [2];
  logic [127:0] wdata [2];
  logic [127:0] rdata [2];
`ifdef PMEM_STATS_EN
  logic [15:0]  rdCnt [2];
  logic [15:0]  wrCnt [2];
`endif

  pmem_responder #(.LATENCY(4), .IDX_BITS(12)) dut0 (
    .clk          (clk),
    .rst          (rst[0]),
    .pmem_read    (rd[0]),
    .pmem_write   (wr[0]),
    .pmem_address (addr[0]),
    .pmem_wdata   (wdata[0]),
    .pmem_resp    (resp[0]),
    .pmem_rdata   (rdata[0]),
    .pmem_busy    (busy[0])
`ifdef PMEM_STATS_EN
    ,
    .rd_count     (rdCnt[0]),
    .wr_count     (wrCnt[0])
`endif
  );

  pmem_responder #(.LATENCY(1), .IDX_BITS(12)) dut1 (
    .clk          (clk),
    .rst          (rst[1]),
    .pmem_read    (rd[1]),
    .pmem_write   (wr[1]),
    .pmem_address (addr[1]),
    .pmem_wdata   (wdata[1]),
    .pmem_resp    (resp[1]),
    .pmem_rdata   (rdata[1]),
    .pmem_busy    (busy[1])
`ifdef PMEM_STATS_EN
    ,
    .rd_count     (rdCnt[1]),
    .wr_count     (wrCnt[1])
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit           isWrite;
    logic [127:0] data;
  } exp_t;

  typedef struct {
    logic         w;
    logic         r;
    logic [15:0]  a;
    logic [127:0] d;
    logic [127:0] exp;
    string        name;
  } vec_t;

  exp_t         sb0 [$];
  exp_t         sb1 [$];
  logic [127:0] lastRd [2];
  int           expRd  [2];
  int           expWr  [2];

  localparam logic [127:0] D1  = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
  localparam logic [127:0] D2  = 128'h0808_0808_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] D3  = 128'hC0FF_EE00_0000_0000_0000_0000_0000_0100;
  localparam logic [127:0] D4  = 128'h0300_0300_0300_0300_ABCD_ABCD_ABCD_ABCD;
  localparam logic [127:0] D5  = 128'hFACE_B00C_0000_0000_1234_5678_9ABC_DEF0;
  localparam logic [127:0] A40 = 128'h4040_4040_4040_4040_4040_4040_4040_4040;
  localparam logic [127:0] E1  = 128'h1111_0000_1111_0000_1111_0000_1111_0010;
  localparam logic [127:0] E2  = 128'h2222_0000_2222_0000_2222_0000_2222_0020;

  function automatic int latOf(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExp(input int u, input bit isWrite, input logic [127:0] data);
    exp_t e;
    e.isWrite = isWrite;
    e.data    = data;
    if (u == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Drive a request now and record what its completion must look like.
  task automatic issue(input int u, input logic w, input logic r, input logic [15:0] a,
                       input logic [127:0] d, input logic [127:0] exp);
    wr[u]    = w;
    rd[u]    = r;
    addr[u]  = a;
    wdata[u] = d;
    if (w) begin
      pushExp(u, 1'b1, '0);
      expWr[u]++;
    end else begin
      pushExp(u, 1'b0, exp);
      expRd[u]++;
    end
  endtask

  // Wait (bounded) for pmem_resp, checking latency and busy along the way.
  task automatic waitResp(input int u, input int expLat, input bit idleFirst, input string name);
    int  n;
    bit  got;
    bit  busyOk;
    n      = 0;
    got    = 1'b0;
    busyOk = 1'b1;
    while (!got && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (idleFirst && n == 1) begin
        if (busy[u] !== 1'b0) busyOk = 1'b0;
      end else begin
        if (busy[u] !== 1'b1) busyOk = 1'b0;
      end
      if (resp[u] === 1'b1) got = 1'b1;
    end
    checkOutput({name, "_resp_seen"}, got, 1'b1);
    if (got) begin
      checkOutput({name, "_latency"}, n, expLat);
      checkOutput({name, "_busy"}, busyOk, 1'b1);
    end
  endtask

  // Drop the request on the response edge and confirm the idle gap.
  task automatic finishTxn(input int u, input string name);
    wr[u] = 1'b0;
    rd[u] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_idle_busy"}, busy[u], 1'b0);
    checkOutput({name, "_idle_resp"}, resp[u], 1'b0);
  endtask

  task automatic applyStimulus(input int u, input logic w, input logic r, input logic [15:0] a,
                               input logic [127:0] d, input logic [127:0] exp, input string name);
    issue(u, w, r, a, d, exp);
    waitResp(u, latOf(u), 1'b0, name);
    finishTxn(u, name);
  endtask

  // Scoreboard monitor: every response must match the oldest outstanding request.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (resp[u] === 1'b1) begin
        exp_t e;
        bit   have;
        have = 1'b0;
        if (u == 0 && sb0.size() > 0) begin
          e    = sb0.pop_front();
          have = 1'b1;
        end else if (u == 1 && sb1.size() > 0) begin
          e    = sb1.pop_front();
          have = 1'b1;
        end
        checkOutput($sformatf("resp_expected_u%0d", u), have, 1'b1);
        if (have) begin
          if (e.isWrite) begin
            checkOutput($sformatf("rdata_held_u%0d", u), rdata[u], lastRd[u]);
          end else begin
            checkOutput($sformatf("rdata_u%0d", u), rdata[u], e.data);
            lastRd[u] = e.data;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 16'h1230, D1,  128'h0, "wr_1230"};
    vecs[1] = '{1'b0, 1'b1, 16'h123C, '0,  D1,     "rd_123C"};
    vecs[2] = '{1'b1, 1'b0, 16'h0080, D2,  128'h0, "wr_0080"};
    vecs[3] = '{1'b1, 1'b0, 16'h0100, D3,  128'h0, "wr_0100"};
    vecs[4] = '{1'b1, 1'b0, 16'h0300, D4,  128'h0, "wr_0300"};
    vecs[5] = '{1'b0, 1'b1, 16'h0085, '0,  D2,     "rd_0085"};
    vecs[6] = '{1'b1, 1'b0, 16'h1231, D5,  128'h0, "wr_1231"};
    vecs[7] = '{1'b0, 1'b1, 16'h1238, '0,  D5,     "rd_1238"};
    vecs[8] = '{1'b1, 1'b1, 16'h0200, 128'h5A, 128'h0, "wrrd_0200"};
    vecs[9] = '{1'b0, 1'b1, 16'h0200, '0,  128'h5A, "rd_0200"};

    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; rd[u] = 1'b0; wr[u] = 1'b0;
      addr[u] = '0; wdata[u] = '0;
      lastRd[u] = '0; expRd[u] = 0; expWr[u] = 0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("reset_resp_u%0d", u), resp[u], 1'b0);
      checkOutput($sformatf("reset_busy_u%0d", u), busy[u], 1'b0);
      checkOutput($sformatf("reset_rdata_u%0d", u), rdata[u], '0);
      rst[u] = 1'b0;
    end
    @(negedge clk);

    $display("[TB] table vectors, LATENCY=4");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].exp, vecs[i].name);
    end

    $display("[TB] back-to-back write then read");
    issue(0, 1'b1, 1'b0, 16'h0040, A40, '0);
    waitResp(0, 4, 1'b0, "b2b_wr");
    issue(0, 1'b0, 1'b1, 16'h0080, '0, D2);
    waitResp(0, 5, 1'b1, "b2b_rd");
    finishTxn(0, "b2b_rd");
    applyStimulus(0, 1'b0, 1'b1, 16'h0040, '0, A40, "rd_0040");

    $display("[TB] abort during wait");
    wr[0] = 1'b1; addr[0] = 16'h0100; wdata[0] = 128'h1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    wr[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("abort_busy", busy[0], 1'b0);
    repeat (6) @(negedge clk);
    applyStimulus(0, 1'b0, 1'b1, 16'h0100, '0, D3, "rd_after_abort");

    $display("[TB] reset mid-wait");
    wr[0] = 1'b1; addr[0] = 16'h0300; wdata[0] = ~D4;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("rstwait_resp", resp[0], 1'b0);
    checkOutput("rstwait_busy", busy[0], 1'b0);
    checkOutput("rstwait_rdata", rdata[0], '0);
    rst[0] = 1'b0; wr[0] = 1'b0;
    lastRd[0] = '0; expRd[0] = 0; expWr[0] = 0;
    repeat (6) @(negedge clk);
    applyStimulus(0, 1'b0, 1'b1, 16'h0300, '0, D4, "rd_after_rst");
    applyStimulus(0, 1'b0, 1'b1, 16'h1230, '0, D5, "rd_1230_final");

    $display("[TB] LATENCY=1 sequence");
    applyStimulus(1, 1'b1, 1'b0, 16'h0010, E1, '0, "l1_wr_0010");
    applyStimulus(1, 1'b0, 1'b1, 16'h0010, '0, E1, "l1_rd_0010");
    applyStimulus(1, 1'b1, 1'b0, 16'h0020, E2, '0, "l1_wr_0020");
    applyStimulus(1, 1'b0, 1'b1, 16'h002F, '0, E2, "l1_rd_002F");
    applyStimulus(1, 1'b0, 1'b1, 16'h0018, '0, E1, "l1_rd_0018");

    repeat (2) @(negedge clk);
    checkOutput("sb0_drained", sb0.size(), 0);
    checkOutput("sb1_drained", sb1.size(), 0);
`ifdef PMEM_STATS_EN
    checkOutput("rd_count_u0", rdCnt[0], expRd[0]);
    checkOutput("wr_count_u0", wrCnt[0], expWr[0]);
    checkOutput("rd_count_u1", rdCnt[1], 3);
    checkOutput("wr_count_u1", wrCnt[1], 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Physical-memory responder for the cache's `pmem_*` port. It accepts one line-wide read or write request at a time and holds it for a programmable latency. It then commits the write to, or fetches the read from, an internal line array and pulses `pmem_resp`. It sits between the L1 cache controller and the top level, standing in for main memory in both simulation and FPGA builds.

## Interface
- `LATENCY`, 4: cycles from request acceptance to `pmem_resp`. Legal range 1..15.
- `IDX_BITS`, 12: line-index width. The array holds 2^IDX_BITS lines of 128 bits.
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: reset. Synchronous, active-high.
- `pmem_read` in 1: read request. Held high until `pmem_resp`.
- `pmem_write` in 1: write request. Held high until `pmem_resp`.
- `pmem_address` in 16: byte address.
  - Bits [3:0] are ignored.
  - Line index is `pmem_address[IDX_BITS+3:4]`.
- `pmem_wdata` in 128: write line.
- `pmem_resp` out 1: one-cycle completion pulse.
- `pmem_rdata` out 128: registered read line. Valid in the `pmem_resp` cycle; holds its value until the next read completes.
- `pmem_busy` out 1: high in `WAIT` and `RESP`.

## Operation
- States are `IDLE`, `WAIT` and `RESP`. `RESP` lasts exactly one cycle.
- **`IDLE`**
  - If `pmem_write` or `pmem_read` is high, latch the opcode, the line index and `pmem_wdata`, and load `cnt = LATENCY-1`.
  - Go to `RESP` if `LATENCY == 1`, otherwise go to `WAIT`.
  - If both request lines are high, treat the request as a write and ignore the read.
- **`WAIT`**
  - Decrement `cnt`.
  - When `cnt == 1` on a clock edge, go to `RESP` on that edge.
  - On that same edge, a write commits `wdata_q` to `array[idx_q]`, and a read loads `pmem_rdata <= array[idx_q]`.
  - For `LATENCY == 1`, the commit or load happens on the `IDLE -> RESP` edge, using the live inputs.
- **`RESP`**
  - Assert `pmem_resp` and go to `IDLE`.
  - The requester drops or changes its request on the edge where it samples `pmem_resp`.
  - A request that is high in the following `IDLE` cycle is a new request. This allows a write-back followed immediately by an allocate read.
- **Abort:** if the latched request line drops during `WAIT`, go to `IDLE`. No commit, no `pmem_resp`, and `pmem_rdata` is unchanged.
- **Latching:** address and data are taken only at acceptance. Changes to the inputs during `WAIT` are ignored, other than the abort rule above.
- **Array:** not reset. Contents survive `rst`. Initial contents are X in simulation.
- **Reset:**
  - `rst` takes priority in any state, including mid-`WAIT`.
  - Next state is `IDLE` and `cnt = 0`.
  - Any pending write is discarded.
  - Output reset values: `pmem_resp = 0`, `pmem_busy = 0`, `pmem_rdata = 0`.

## Timing
- Request high in `IDLE` during cycle T gives `pmem_resp` in cycle T+`LATENCY`.
- Read data is valid in cycle T+`LATENCY`.
- A written line is readable by a request accepted at T+`LATENCY`+1 or later.
- Back-to-back throughput is one request per `LATENCY`+1 cycles.
- `pmem_resp` and `pmem_busy` are registered state decodes; neither has a combinational path from any input.

## Configuration
- Macro: `PMEM_STATS_EN`.
- When defined, the block adds two outputs:
  - `rd_count` out 16: saturating count of completed reads.
  - `wr_count` out 16: saturating count of completed writes.
- Counting rules:
  - Each counter increments in its `pmem_resp` cycle.
  - Aborted requests are not counted.
  - Both counters reset to 0 on `rst`.
  - Each counter saturates at 16'hFFFF.
- When not defined, these ports and their registers do not exist, and behaviour is otherwise identical.

## Test plan
- **Write then read, `LATENCY`=4:**
  - Stimulus: write `0x1230` with data `128'hDEAD...BEEF`, then read `0x123C`.
  - Required: each `pmem_resp` arrives 4 cycles after its request; `pmem_rdata` = `128'hDEAD...BEEF`.
- **Back-to-back write then read:**
  - Stimulus: write `0x0040`, with `pmem_read` of `0x0080` asserted the cycle after `resp`.
  - Required: the read is accepted immediately; `resp` arrives 4 cycles later; `pmem_busy` is low for exactly one cycle between the two requests.
- **Abort:**
  - Stimulus: write `0x0100` with `128'h1`, dropped at T+2; then read `0x0100`.
  - Required: no `resp` for the write; the read returns the prior contents, not `128'h1`.
- **Simultaneous read and write:**
  - Stimulus: both request lines high on `0x0200` with `128'h5A`.
  - Required: a write occurs; a subsequent read returns `128'h5A`.
- **Reset mid-`WAIT`:**
  - Stimulus: `rst` at T+2 of a write.
  - Required: next cycle state is `IDLE` with `pmem_resp`=0, `pmem_busy`=0, `pmem_rdata`=0; the write is not committed.
- **`LATENCY`=1 and stats:**
  - Stimulus: `LATENCY`=1 with `PMEM_STATS_EN` defined; issue 3 reads and 2 writes.
  - Required: each `resp` arrives at T+1; final `rd_count`=3 and `wr_count`=2.
